// File: rtl/croc_vector_checker.sv
// ---------------------------------------------------------------------------
// croc_vector_checker
//
// Response checker for vector-replay setups. Expected output vectors and
// per-bit compare masks are queued in a small FIFO. Each accepted DUT sample
// pops one entry into a delay pipeline. The sample that arrives Latency
// samples later is compared against that entry. Mismatches are counted,
// the first failing vector is captured, and the checker can halt on error.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high (dominates everything)
//   clear_i        synchronous clear; same effect as rst_i
//   en_i           enable checking (IDLE <-> RUN)
//   stop_on_err_i  go to HALT on the first mismatch
//   exp_valid_i    expected vector valid
//   exp_ready_o    FIFO can accept (not full, not halted)
//   exp_data_i     expected DUT output values
//   exp_mask_i     1 = compare bit, 0 = don't care
//   sample_i       DUT outputs valid this cycle
//   dut_data_i     DUT outputs
//   vec_cnt_o      vectors compared (saturating)
//   err_cnt_o      vectors mismatched (saturating)
//   err_o          sticky: any mismatch seen
//   underflow_o    sticky: accepted sample while the FIFO was empty
//   halted_o       checker is in HALT
//   first_idx_o    vec_cnt value of the first mismatching vector
//   first_diff_o   (dut ^ exp) & mask of the first mismatch
// ---------------------------------------------------------------------------
module croc_vector_checker #(
    parameter int DataWidth = 32,
    parameter int Latency   = 1,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 stop_on_err_i,
    input  logic                 exp_valid_i,
    output logic                 exp_ready_o,
    input  logic [DataWidth-1:0] exp_data_i,
    input  logic [DataWidth-1:0] exp_mask_i,
    input  logic                 sample_i,
    input  logic [DataWidth-1:0] dut_data_i,
    output logic [CntWidth-1:0]  vec_cnt_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic                 err_o,
    output logic                 underflow_o,
    output logic                 halted_o,
    output logic [CntWidth-1:0]  first_idx_o,
    output logic [DataWidth-1:0] first_diff_o
);

    localparam int PtrW = $clog2(FifoDepth);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    genvar gi;

    state_t state_reg, state_next;
    logic   running;
    logic   halted;

    // Expected-vector FIFO
    logic [DataWidth-1:0] fifo_data_mem [FifoDepth];
    logic [DataWidth-1:0] fifo_mask_mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_reg;
    logic [PtrW-1:0]      rd_ptr_reg;
    logic [PtrW:0]        count_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DataWidth-1:0] head_data;
    logic [DataWidth-1:0] head_mask;

    logic push;
    logic pop;
    logic sample_acc;

    // Compare slot and result
    logic                 cmp_valid;
    logic [DataWidth-1:0] cmp_data;
    logic [DataWidth-1:0] cmp_mask;
    logic [DataWidth-1:0] diff;
    logic                 compare;
    logic                 mismatch;

    // Statistics
    logic [CntWidth-1:0]  vec_cnt_reg;
    logic [CntWidth-1:0]  err_cnt_reg;
    logic                 err_reg;
    logic                 underflow_reg;
    logic [CntWidth-1:0]  first_idx_reg;
    logic [DataWidth-1:0] first_diff_reg;

    // -----------------------------------------------------------------------
    // Handshake qualifiers. clear_i / rst_i drop a concurrent push or sample.
    // -----------------------------------------------------------------------
    assign fifo_full   = (count_reg == (PtrW+1)'(FifoDepth));
    assign fifo_empty  = (count_reg == '0);
    assign exp_ready_o = !fifo_full && !halted;
    assign push        = exp_valid_i && exp_ready_o && !clear_i && !rst_i;
    assign sample_acc  = sample_i && running && !clear_i && !rst_i;
    assign pop         = sample_acc && !fifo_empty;

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (en_i) state_next = ST_RUN;
            ST_RUN: begin
                // A mismatch with stop enabled wins over a simultaneous disable.
                if (mismatch && stop_on_err_i) begin
                    state_next = ST_HALT;
                end else if (!en_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state_reg == ST_RUN);
        halted  = (state_reg == ST_HALT);
    end

    assign halted_o = halted;

    // -----------------------------------------------------------------------
    // FIFO. The head is read asynchronously: with Latency=0 it is compared in
    // the same cycle as the sample. Count is registered, so an entry written
    // in cycle t only becomes visible (non-empty) in cycle t+1.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_mem[wr_ptr_reg] <= exp_data_i;
            fifo_mask_mem[wr_ptr_reg] <= exp_mask_i;
        end
    end

    assign head_data = fifo_data_mem[rd_ptr_reg];
    assign head_mask = fifo_mask_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PtrW+1)'(1);
                2'b01:   count_reg <= count_reg - (PtrW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Delay pipeline between pop and compare. It only advances on accepted
    // samples, so disabling mid-run keeps entries aligned with the DUT stream.
    // -----------------------------------------------------------------------
    if (Latency > 0) begin : g_pipe
        logic                 pipe_valid_reg [Latency];
        logic [DataWidth-1:0] pipe_data_reg  [Latency];
        logic [DataWidth-1:0] pipe_mask_reg  [Latency];

        for (gi = 0; gi < Latency; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i) begin
                    if (rst_i || clear_i) begin
                        pipe_valid_reg[gi] <= 1'b0;
                    end else if (sample_acc) begin
                        // Empty FIFO feeds a bubble into the pipeline.
                        pipe_valid_reg[gi] <= !fifo_empty;
                        pipe_data_reg[gi]  <= head_data;
                        pipe_mask_reg[gi]  <= head_mask;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk_i) begin
                    if (rst_i || clear_i) begin
                        pipe_valid_reg[gi] <= 1'b0;
                    end else if (sample_acc) begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                        pipe_data_reg[gi]  <= pipe_data_reg[gi-1];
                        pipe_mask_reg[gi]  <= pipe_mask_reg[gi-1];
                    end
                end
            end
        end

        assign cmp_valid = pipe_valid_reg[Latency-1];
        assign cmp_data  = pipe_data_reg[Latency-1];
        assign cmp_mask  = pipe_mask_reg[Latency-1];
    end else begin : g_nopipe
        // Zero latency: the head being popped is the one compared.
        assign cmp_valid = !fifo_empty;
        assign cmp_data  = head_data;
        assign cmp_mask  = head_mask;
    end

    assign diff     = (dut_data_i ^ cmp_data) & cmp_mask;
    assign compare  = sample_acc && cmp_valid;
    assign mismatch = compare && (|diff);

    // -----------------------------------------------------------------------
    // Statistics, all registered one cycle after the sample.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            vec_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            underflow_reg  <= 1'b0;
            first_idx_reg  <= '0;
            first_diff_reg <= '0;
        end else begin
            if (compare && (vec_cnt_reg != '1)) begin
                vec_cnt_reg <= vec_cnt_reg + CntWidth'(1);
            end
            if (mismatch) begin
                if (err_cnt_reg != '1) begin
                    err_cnt_reg <= err_cnt_reg + CntWidth'(1);
                end
                err_reg <= 1'b1;
                // Only the very first failure is captured.
                if (!err_reg) begin
                    first_idx_reg  <= vec_cnt_reg;
                    first_diff_reg <= diff;
                end
            end
            if (sample_acc && fifo_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign vec_cnt_o    = vec_cnt_reg;
    assign err_cnt_o    = err_cnt_reg;
    assign err_o        = err_reg;
    assign underflow_o  = underflow_reg;
    assign first_idx_o  = first_idx_reg;
    assign first_diff_o = first_diff_reg;

endmodule

// File: tb/tb_croc_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_croc_vector_checker
//
// Directed bench. u_dut uses default parameters (Latency=1, FifoDepth=4,
// CntWidth=16); u_sat uses Latency=0, CntWidth=4 for the saturation case.
// For every sample driven into u_dut the expected statistics are pushed into
// a queue; a monitor pops and compares them the cycle after each sample.
// ---------------------------------------------------------------------------
module tb_croc_vector_checker;

    typedef struct packed {
        logic [15:0] vec;
        logic [15:0] err;
        logic        e;
        logic        uf;
        logic        h;
        logic [15:0] fidx;
        logic [31:0] fdiff;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, en, stop, exp_valid, sample;
    logic [31:0] exp_data, exp_mask, dut_data;
    logic        exp_ready, err, uf, halted;
    logic [15:0] vec_cnt, err_cnt, first_idx;
    logic [31:0] first_diff;

    logic        s_clear, s_en, s_stop, s_exp_valid, s_sample;
    logic [31:0] s_exp_data, s_exp_mask, s_dut;
    logic        s_exp_ready, s_err, s_uf, s_halted;
    logic [3:0]  s_vec, s_err_cnt, s_fidx;
    logic [31:0] s_fdiff;

    croc_vector_checker u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en),
        .stop_on_err_i(stop), .exp_valid_i(exp_valid), .exp_ready_o(exp_ready),
        .exp_data_i(exp_data), .exp_mask_i(exp_mask), .sample_i(sample),
        .dut_data_i(dut_data), .vec_cnt_o(vec_cnt), .err_cnt_o(err_cnt),
        .err_o(err), .underflow_o(uf), .halted_o(halted),
        .first_idx_o(first_idx), .first_diff_o(first_diff)
    );

    croc_vector_checker #(.DataWidth(32), .Latency(0), .FifoDepth(4), .CntWidth(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(s_clear), .en_i(s_en),
        .stop_on_err_i(s_stop), .exp_valid_i(s_exp_valid), .exp_ready_o(s_exp_ready),
        .exp_data_i(s_exp_data), .exp_mask_i(s_exp_mask), .sample_i(s_sample),
        .dut_data_i(s_dut), .vec_cnt_o(s_vec), .err_cnt_o(s_err_cnt),
        .err_o(s_err), .underflow_o(s_uf), .halted_o(s_halted),
        .first_idx_o(s_fidx), .first_diff_o(s_fdiff)
    );

    int   total = 0;
    int   bad   = 0;
    int   nsamp = 0;
    exp_t sb_q[$];
    logic samp_seen = 1'b0;

    function automatic exp_t mk(input logic [15:0] v, input logic [15:0] er,
                                input logic e, input logic u, input logic h,
                                input logic [15:0] fi, input logic [31:0] fd);
        exp_t r;
        r = {v, er, e, u, h, fi, fd};
        return r;
    endfunction

    function automatic exp_t snap();
        exp_t r;
        r = {vec_cnt, err_cnt, err, uf, halted, first_idx, first_diff};
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: stats appear the cycle after a sample; compare on the negedge.
    always @(posedge clk) samp_seen <= sample;

    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t want;
        if (samp_seen) begin
            got = snap();
            total++;
            nsamp++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: sample %0d with no expectation queued", nsamp);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL sample%0d: got vec=%0d err=%0d e=%b uf=%b h=%b fidx=%0d fdiff=%h want vec=%0d err=%0d e=%b uf=%b h=%b fidx=%0d fdiff=%h",
                             nsamp, got.vec, got.err, got.e, got.uf, got.h, got.fidx, got.fdiff,
                             want.vec, want.err, want.e, want.uf, want.h, want.fidx, want.fdiff);
                end else begin
                    $display("[tb] sample %0d vec=%0d err=%0d e=%b uf=%b h=%b fidx=%0d fdiff=%h",
                             nsamp, got.vec, got.err, got.e, got.uf, got.h, got.fidx, got.fdiff);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] m);
        check("push_ready", exp_ready, 1);
        exp_valid = 1'b1;
        exp_data  = d;
        exp_mask  = m;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic samp(input logic [31:0] d, input exp_t e);
        sb_q.push_back(e);
        sample   = 1'b1;
        dut_data = d;
        tick();
        sample   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_stats", snap(), 0);
        check("clear_ready", exp_ready, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; clear = 1'b0; en = 1'b0; stop = 1'b0;
        exp_valid = 1'b0; sample = 1'b0;
        exp_data = '0; exp_mask = '0; dut_data = '0;
        s_clear = 1'b0; s_en = 1'b0; s_stop = 1'b0; s_exp_valid = 1'b0; s_sample = 1'b0;
        s_exp_data = '0; s_exp_mask = '0; s_dut = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_stats", snap(), 0);
        check("reset_ready", exp_ready, 1);
        check("s_reset_stats", {s_vec, s_err_cnt, s_err, s_uf, s_halted, s_fidx, s_fdiff}, 0);
        check("s_reset_ready", s_exp_ready, 1);

        // Latency-1 alignment: first sample only primes the pipeline
        en = 1'b1;
        tick();
        push(32'h1234, '1);
        push(32'h5678, '1);
        samp(32'hDEAD_BEEF, mk(0, 0, 0, 0, 0, 0, 0));
        samp(32'h1234,      mk(1, 0, 0, 0, 0, 0, 0));
        samp(32'h5678,      mk(2, 0, 0, 1, 0, 0, 0));
        do_clear();
        tick();

        // Masked mismatch, first capture kept, mask-zero pass, underflow
        push(32'hFF00, 32'h0F00);
        push(32'h1, '1);
        push(32'h2, '1);
        push(32'hABCD, 32'h0);
        samp(32'h0,        mk(0, 0, 0, 0, 0, 0, 0));
        samp(32'hF000,     mk(1, 1, 1, 0, 0, 0, 32'h0F00));
        samp(32'h3,        mk(2, 2, 1, 0, 0, 0, 32'h0F00));
        samp(32'h2,        mk(3, 2, 1, 0, 0, 0, 32'h0F00));
        samp(32'h12345678, mk(4, 2, 1, 1, 0, 0, 32'h0F00));
        samp(32'h0,        mk(4, 2, 1, 1, 0, 0, 32'h0F00));
        do_clear();
        tick();

        // en low mid-run: samples ignored, alignment kept, push still accepted
        push(32'hAAAA, '1);
        push(32'hBBBB, '1);
        samp(32'h0, mk(0, 0, 0, 0, 0, 0, 0));
        en = 1'b0;
        tick();
        samp(32'hAAAA, mk(0, 0, 0, 0, 0, 0, 0));
        push(32'hCCCC, '1);
        en = 1'b1;
        tick();
        samp(32'hAAAA, mk(1, 0, 0, 0, 0, 0, 0));
        samp(32'hBBBB, mk(2, 0, 0, 0, 0, 0, 0));
        samp(32'hCCCC, mk(3, 0, 0, 1, 0, 0, 0));
        do_clear();
        tick();

        // FIFO full, then stop-on-error on the third vector
        stop = 1'b1;
        push(32'h10, '1);
        push(32'h11, '1);
        push(32'h12, '1);
        push(32'h13, '1);
        check("full_ready", exp_ready, 0);
        samp(32'h0, mk(0, 0, 0, 0, 0, 0, 0));
        check("ready_after_pop", exp_ready, 1);
        samp(32'h10, mk(1, 0, 0, 0, 0, 0, 0));
        push(32'h14, '1);
        samp(32'h11, mk(2, 0, 0, 0, 0, 0, 0));
        samp(32'h99, mk(3, 1, 1, 0, 1, 2, 32'h8B));
        check("halt_ready", exp_ready, 0);
        samp(32'h13, mk(3, 1, 1, 0, 1, 2, 32'h8B));
        do_clear();
        stop = 1'b0;
        tick();

        // clear concurrent with push: push dropped, so next sample underflows
        clear = 1'b1;
        exp_valid = 1'b1;
        exp_data = 32'h77;
        exp_mask = '1;
        tick();
        clear = 1'b0;
        exp_valid = 1'b0;
        tick();
        samp(32'h77, mk(0, 0, 0, 1, 0, 0, 0));
        do_clear();
        tick();

        // Saturation on the 4-bit, zero-latency instance
        s_en = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            s_exp_valid = 1'b1;
            s_exp_data  = i;
            s_exp_mask  = '1;
            tick();
            s_exp_valid = 1'b0;
            s_sample    = 1'b1;
            s_dut       = ~i;
            tick();
            s_sample    = 1'b0;
            if (i == 0) begin
                check("s_first_vec", s_vec, 1);
                check("s_first_err", s_err_cnt, 1);
                check("s_first_diff", s_fdiff, 32'hFFFF_FFFF);
            end
        end
        check("s_sat_vec", s_vec, 15);
        check("s_sat_err", s_err_cnt, 15);
        check("s_sat_flags", {s_err, s_uf, s_halted, s_exp_ready}, 4'b1001);
        check("s_sat_fidx", s_fidx, 0);

        // rst mid-run resets everything, including pipeline contents
        push(32'h55, '1);
        samp(32'h0, mk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_stats", snap(), 0);
        check("rst_mid_ready", exp_ready, 1);
        check("s_rst_mid_stats", {s_vec, s_err_cnt, s_err, s_uf, s_halted, s_fidx, s_fdiff}, 0);
        tick();
        samp(32'h55, mk(0, 0, 0, 1, 0, 0, 0));

        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
